system_0_timer_sched: RTL and testbench
=======================================

# system_0_timer_sched

Round-robin scheduler that shares the single interval-timer peripheral among up to `NUM_REQ` hardware requesters.
- Each requester asks for one one-shot timeout of a given length; the scheduler grants one requester at a time and programs the timer over its 16-bit Avalon-style slave port (period low/high, control).
- It waits for the timer interrupt, clears the timer status, then returns a one-cycle `done` pulse to the owner.
- It sits between the audio-path hardware clients and the timer peripheral, replacing CPU-driven timer programming for those clients.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2–8.
- `clk` in 1: system clock, shared with the timer.
- `reset` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: level request, one bit per requester; held until the matching `grant` bit rises.
- `period` in 32*NUM_REQ: timeout length in clk cycles for requester i at bits [32i+31:32i]; sampled at arbitration.
- `cancel` in NUM_REQ: abort request; honoured only for the current owner in RUN.
- `grant` out NUM_REQ: one-hot current owner; all zero when idle.
- `done` out NUM_REQ: one-cycle one-hot pulse on timeout completion.
- `busy` out 1: high in any state other than IDLE.
- `tmr_address` out 3: timer register select (0 status, 1 control, 2 period_l, 3 period_h).
- `tmr_chipselect` out 1: timer select.
- `tmr_write_n` out 1: active-low write strobe.
- `tmr_writedata` out 16: timer write data.
- `tmr_irq` in 1: timer interrupt, level, stays high until status is written.

## Operation
- Timer writes complete in one cycle with no waitrequest. The scheduler never reads the timer.
- State machine, one-hot or encoded: IDLE, WR_PL, WR_PH, WR_CTL, RUN, STOP, CLR, DONE.
- **IDLE**
  - If `req` is nonzero, pick the winner round-robin: search starts at (last winner + 1) mod NUM_REQ.
  - After reset the pointer makes index 0 highest priority.
  - Latch `L = max(period_winner, 2) − 1` (32-bit), set `grant`, go to WR_PL.
- **WR_PL**: write address 2, data `L[15:0]`; go to WR_PH.
- **WR_PH**: write address 3, data `L[31:16]`; go to WR_CTL.
- **WR_CTL**: write address 1, data 0x0005 (ITO=1, CONT=0, START=1); go to RUN.
- **RUN** (no bus activity):
  - `tmr_irq` high → CLR with done pending.
  - Else `cancel[owner]` high → STOP with done not pending.
  - `tmr_irq` and `cancel` in the same cycle: irq wins and `done` is still issued.
- **STOP**: write address 1, data 0x0008 (STOP=1, ITO=0); go to CLR.
- **CLR**: write address 0, data 0x0000 to clear the timeout flag.
  - Done pending → DONE.
  - Otherwise drop `grant` and go to IDLE.
- **DONE**: pulse `done[owner]` for one cycle, drop `grant`, go to IDLE.
- Bus decode is from the state register only:
  - In write states: `tmr_chipselect=1`, `tmr_write_n=0`.
  - Otherwise: `tmr_chipselect=0`, `tmr_write_n=1`, `tmr_address=0`, `tmr_writedata=0`.
- The owner's `req` is ignored after grant; one grant serves exactly one timeout.
- `cancel` for a non-owner, or outside RUN, is ignored.
- Changes to `req` or `period` for non-owners during a job do not affect that job.

## Timing
- Reset (synchronous):
  - State IDLE, round-robin pointer set so index 0 wins first.
  - `grant=0`, `done=0`, `busy=0`, `tmr_chipselect=0`, `tmr_write_n=1`, `tmr_address=0`, `tmr_writedata=0`.
- Reset asserted mid-job: all outputs take reset values on the next edge and no `done` is issued. The timer is not stopped by this block; its next irq is cleared by the first CLR of a later job.
- Latency, with `req` seen in IDLE at cycle 0:
  - `grant` and the WR_PL write at cycle 1.
  - WR_PH at cycle 2, WR_CTL at cycle 3, RUN from cycle 4.
  - Irq seen at cycle N → CLR write at N+1, `done` at N+2, IDLE at N+3.
- Minimum spacing between jobs: new arbitration in the IDLE cycle that follows DONE or CLR.
- `done` and `grant` never overlap a different owner's bits. `grant` falls in the same cycle `done` is high.

## Test plan
- **Single request:** `req=0001`, `period[0]=100`.
  - Required: writes (2,0x0063), (3,0x0000), (1,0x0005) at cycles 1–3.
  - Timer irq follows; then write (0,0x0000) and `done=0001` once; `busy` low afterwards.
- **Simultaneous requests:** `req=0101` twice back-to-back.
  - Required: grant order 0, 2, 0, 2 (round robin), with exactly one `done` per grant.
- **Large and clamped periods:**
  - `period=0x0001_0000` → writes 0xFFFF then 0x0000.
  - `period=0` → L=1, written as 0x0001 and 0x0000.
- **Cancel in RUN:** cancel the owner.
  - Required: write (1,0x0008) then (0,0x0000), no `done`, next requester granted.
  - Cancel from a non-owner has no effect.
- **irq and cancel same cycle:** required CLR write with no STOP write, and `done` pulsed.
- **Reset in RUN:** `reset` high for 1 cycle.
  - Required: all outputs at reset values next cycle, no `done`.
  - A new `req=0010` then completes normally and the stale irq is cleared.

Source files
------------

// File: rtl/system_0_timer_sched.sv
// Round-robin sharing of one interval timer among NUM_REQ requesters.
// Each grant programs a one-shot timeout, waits for the irq, clears it and pulses done.
module system_0_timer_sched #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  period,
    input  logic [NUM_REQ-1:0]     cancel,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);

    // state  | meaning
    // IDLE   | no owner, arbitrate among req
    // WR_PL  | write period low half
    // WR_PH  | write period high half
    // WR_CTL | start one-shot with interrupt enabled
    // RUN    | wait for irq or owner cancel
    // STOP   | stop the timer after a cancel
    // CLR    | clear the timeout status flag
    // DONE   | pulse done to the owner
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_PL  = 3'd1;
    localparam logic [2:0] WR_PH  = 3'd2;
    localparam logic [2:0] WR_CTL = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
    localparam logic [2:0] CLR    = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]         state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      last;
    logic [IW-1:0]      win;
    logic [IW-1:0]      cand;
    logic               found;
    logic [31:0]        win_per;
    logic [31:0]        win_load;
    logic [31:0]        lval;
    logic               done_pend;
    logic [NUM_REQ-1:0] owner_oh;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(last) + 1 + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_per  = period[{win, 5'b00000} +: 32];
        // The timer counts load+1 cycles; a period below 2 is clamped.
        win_load = (win_per < 32'd2) ? 32'd1 : win_per - 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= IW'(NUM_REQ - 1);
            owner     <= '0;
            lval      <= '0;
            done_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_pend <= 1'b0;
                    if (found) begin
                        owner <= win;
                        last  <= win;
                        lval  <= win_load;
                        state <= WR_PL;
                    end
                end
                WR_PL:  state <= WR_PH;
                WR_PH:  state <= WR_CTL;
                WR_CTL: state <= RUN;
                RUN: begin
                    if (tmr_irq) begin
                        done_pend <= 1'b1;
                        state     <= CLR;
                    end else if (cancel[owner]) begin
                        done_pend <= 1'b0;
                        state     <= STOP;
                    end
                end
                STOP:   state <= CLR;
                CLR:    state <= done_pend ? DONE : IDLE;
                DONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_oh = NUM_REQ'(1) << owner;

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        done           = '0;
        case (state)
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = lval[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = lval[31:16];
            end
            WR_CTL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0005;
            end
            STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
            CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd0;
                tmr_writedata  = 16'h0000;
            end
            DONE:    done = owner_oh;
            default: ;
        endcase
    end

    // Grant is already low in the cycle done pulses.
    assign grant = (state != IDLE && state != DONE) ? owner_oh : '0;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_system_0_timer_sched.sv
// Bench for system_0_timer_sched: behavioural interval timer plus round-robin
// and load-value reference, one task per scenario.
module tb_system_0_timer_sched;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [32*N-1:0]  period = '0;
    logic [N-1:0]     cancel = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic             busy;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect;
    logic             tmr_write_n;
    logic [15:0]      tmr_writedata;
    logic             tmr_irq;

    logic  irq_m = 1'b0;
    logic  force_irq = 1'b0;
    bit    tmr_auto = 1'b1;
    assign tmr_irq = irq_m | force_irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    system_0_timer_sched #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .period(period), .cancel(cancel),
        .grant(grant), .done(done), .busy(busy),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer: one-shot of load+1 cycles (capped to keep runs short), irq held until status write.
    logic [31:0] t_per = '0;
    int          t_cnt = 0;
    bit          t_run = 1'b0;
    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: irq_m <= 1'b0;
                3'd1: begin
                    if (tmr_writedata[3]) t_run <= 1'b0;
                    else if (tmr_writedata[2]) begin
                        t_run <= tmr_auto;
                        t_cnt <= (t_per >= 32'd19) ? 20 : int'(t_per) + 1;
                    end
                end
                3'd2: t_per[15:0]  <= tmr_writedata;
                3'd3: t_per[31:16] <= tmr_writedata;
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt <= 1) begin
                irq_m <= 1'b1;
                t_run <= 1'b0;
            end else t_cnt <= t_cnt - 1;
        end
    end

    typedef struct {int c; logic [2:0] a; logic [15:0] d;} wr_t;
    wr_t          wq[$];
    logic [N-1:0] dq[$];
    int           dc[$];
    int           irq_rise = -1;
    int           ovl_err = 0;
    logic         irq_prev = 1'b0;
    logic [N-1:0] done_prev = '0;

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) wq.push_back('{cyc, tmr_address, tmr_writedata});
        if (done != '0) begin
            dq.push_back(done);
            dc.push_back(cyc);
            if ((grant & ~done) != '0 || $countones(done) != 1) ovl_err++;
        end
        if (done_prev != '0 && grant != '0) ovl_err++;
        if (tmr_irq && !irq_prev) irq_rise = cyc;
        irq_prev  = tmr_irq;
        done_prev = done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int lim);
        int n = 0;
        while (grant == '0 && n < lim) begin step(); n++; end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy !== 1'b0 && n < lim) begin step(); n++; end
    endtask

    function automatic logic [31:0] load_of(input logic [31:0] p);
        return (p < 32'd2) ? 32'd1 : p - 32'd1;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int prev);
        for (int k = 1; k <= N; k++) if (r[(prev + k) % N]) return (prev + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; req = '0; cancel = '0; force_irq = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        wq.delete(); dq.delete(); dc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant); end
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            errors++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
    endtask

    task automatic test_single();
        logic [2:0]  ea [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
        logic [15:0] ed [4] = '{16'h0063, 16'h0000, 16'h0005, 16'h0000};
        int ec [4];
        int t0;
        do_reset();
        irq_rise = -1;
        period[31:0] = 32'd100;
        req = 4'b0001;
        t0 = cyc;
        wait_grant(5);
        checks++; if (grant !== 4'b0001 || cyc !== t0 + 1) begin
            errors++; $display("FAIL single_grant: got %b at +%0d expected 0001 at +1", grant, cyc - t0);
        end
        req = '0;
        wait_idle(100);
        checks++; if (cyc !== irq_rise + 3) begin
            errors++; $display("FAIL single_idle_lat: got idle at %0d expected %0d", cyc, irq_rise + 3);
        end
        ec = '{t0 + 1, t0 + 2, t0 + 3, irq_rise + 1};
        checks++; if (wq.size() !== 4) begin
            errors++; $display("FAIL single_nwrites: got %0d expected 4", wq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wq[k].a !== ea[k] || wq[k].d !== ed[k] || wq[k].c !== ec[k]) begin
                    errors++;
                    $display("FAIL single_write%0d: got (%0d,%h)@%0d expected (%0d,%h)@%0d",
                             k, wq[k].a, wq[k].d, wq[k].c, ea[k], ed[k], ec[k]);
                end
            end
        end
        checks++; if (dq.size() !== 1 || dq[0] !== 4'b0001 || dc[0] !== irq_rise + 2) begin
            errors++; $display("FAIL single_done: got %0d pulses expected one 0001 at %0d", dq.size(), irq_rise + 2);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] eg [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        period = {4{32'd8}};
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_grant(10);
            checks++; if (grant !== eg[k]) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, eg[k]);
            end
            req = req & ~grant;
            if (k == 1) req = 4'b0101;
            wait_idle(60);
        end
        checks++; if (dq.size() !== 4) begin
            errors++; $display("FAIL rr_ndone: got %0d expected 4", dq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (dq[k] !== eg[k]) begin
                    errors++; $display("FAIL rr_done%0d: got %b expected %b", k, dq[k], eg[k]);
                end
            end
        end
    endtask

    task automatic test_periods();
        logic [31:0]  pv [2] = '{32'h0001_0000, 32'h0000_0000};
        logic [N-1:0] rv [2] = '{4'b0010, 4'b1000};
        logic [31:0]  l;
        do_reset();
        period[63:32]  = pv[0];
        period[127:96] = pv[1];
        for (int k = 0; k < 2; k++) begin
            wq.delete();
            l = load_of(pv[k]);
            req = rv[k];
            wait_grant(5);
            req = '0;
            wait_idle(60);
            checks++; if (wq.size() < 2 || wq[0].d !== l[15:0] || wq[1].d !== l[31:16]) begin
                errors++; $display("FAIL period%0d: got %0d writes lo=%h hi=%h expected lo=%h hi=%h",
                                   k, wq.size(), wq.size() > 0 ? wq[0].d : 16'hx,
                                   wq.size() > 1 ? wq[1].d : 16'hx, l[15:0], l[31:16]);
            end
        end
    endtask

    task automatic test_cancel();
        int n;
        do_reset();
        tmr_auto = 1'b0;
        period = {4{32'd40}};
        req = 4'b0110;
        wait_grant(5);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL cancel_grant1: got %b expected 0010", grant); end
        req = 4'b0100;
        step(); step(); step(); step();
        cancel = 4'b0100;
        step(); step();
        cancel = '0;
        checks++; if (grant !== 4'b0010 || wq.size() !== 3) begin
            errors++; $display("FAIL cancel_nonowner: got grant %b writes %0d expected 0010 and 3", grant, wq.size());
        end
        cancel = 4'b0010;
        step();
        cancel = '0;
        n = 0;
        while (grant !== 4'b0100 && n < 20) begin step(); n++; end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL cancel_next: got %b expected 0100", grant); end
        req = '0;
        cancel = 4'b0100;   // owner cancel during the write sequence is ignored
        step();
        cancel = '0;
        step(); step();
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        wait_idle(20);
        checks++; if (wq.size() !== 9) begin
            errors++; $display("FAIL cancel_nwrites: got %0d expected 9", wq.size());
        end else begin
            checks++; if (wq[3].a !== 3'd1 || wq[3].d !== 16'h0008 || wq[4].a !== 3'd0 || wq[4].d !== 16'h0000) begin
                errors++; $display("FAIL cancel_stopclr: got (%0d,%h),(%0d,%h) expected (1,0008),(0,0000)",
                                   wq[3].a, wq[3].d, wq[4].a, wq[4].d);
            end
            checks++; if (wq[7].d !== 16'h0005 || wq[8].a !== 3'd0) begin
                errors++; $display("FAIL cancel_job2: got ctl %h last addr %0d expected 0005 and 0", wq[7].d, wq[8].a);
            end
        end
        checks++; if (dq.size() !== 1 || dq[0] !== 4'b0100) begin
            errors++; $display("FAIL cancel_done: got %0d pulses expected one 0100", dq.size());
        end
        tmr_auto = 1'b1;
    endtask

    task automatic test_irq_cancel();
        do_reset();
        tmr_auto = 1'b0;
        period[31:0] = 32'd30;
        req = 4'b0001;
        wait_grant(5);
        req = '0;
        step(); step(); step();
        force_irq = 1'b1;
        cancel = 4'b0001;
        step();
        force_irq = 1'b0;
        cancel = '0;
        wait_idle(20);
        checks++; if (wq.size() !== 4 || wq[2].d !== 16'h0005 || wq[3].a !== 3'd0 || wq[3].d !== 16'h0000) begin
            errors++; $display("FAIL irqcancel_writes: got %0d writes expected 4 ending ctl then clear", wq.size());
        end
        checks++; if (dq.size() !== 1 || dq[0] !== 4'b0001) begin
            errors++; $display("FAIL irqcancel_done: got %0d pulses expected one 0001", dq.size());
        end
        tmr_auto = 1'b1;
    endtask

    task automatic test_random();
        int           prev = N - 1;
        int           w;
        int           n;
        logic [31:0]  l;
        logic [N-1:0] eg;
        do_reset();
        for (int i = 0; i < N; i++) period[32*i +: 32] = $urandom_range(0, 30);
        req = N'($urandom_range(1, (1 << N) - 1));
        for (int j = 0; j < 25; j++) begin
            wq.delete();
            w  = rr_pick(req, prev);
            eg = N'(1) << w;
            l  = load_of(period[32*w +: 32]);
            wait_grant(10);
            checks++; if (grant !== eg) begin
                errors++; $display("FAIL rand_grant%0d: got %b expected %b", j, grant, eg);
            end
            prev = w;
            req  = (req & ~eg) | N'($urandom);
            if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) period[32*i +: 32] = $urandom_range(0, 30);
            n = 0;
            while (busy !== 1'b0 && n < 80) begin
                cancel = N'($urandom) & ~eg;
                step();
                n++;
            end
            cancel = '0;
            checks++; if (dq.size() !== j + 1 || dq[j] !== eg) begin
                errors++; $display("FAIL rand_done%0d: got %0d pulses expected %0d ending %b", j, dq.size(), j + 1, eg);
            end
            checks++; if (wq.size() !== 4 || wq[0].d !== l[15:0] || wq[1].d !== l[31:16] || wq[3].a !== 3'd0) begin
                errors++; $display("FAIL rand_writes%0d: got %0d writes expected 4 with load %h", j, wq.size(), l);
            end
        end
        checks++; if (ovl_err !== 0) begin
            errors++; $display("FAIL grant_done_overlap: got %0d violations expected 0", ovl_err);
        end
    endtask

    task automatic test_reset_run();
        int n;
        do_reset();
        period[31:0]  = 32'd50;
        period[63:32] = 32'd50;
        req = 4'b0001;
        wait_grant(5);
        req = '0;
        step(); step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({grant, done, busy, tmr_chipselect, tmr_write_n} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL resetrun_outputs: got grant=%b done=%b busy=%b cs=%b wn=%b expected reset values",
                               grant, done, busy, tmr_chipselect, tmr_write_n);
        end
        n = 0;
        while (tmr_irq !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (tmr_irq !== 1'b1 || dq.size() !== 0) begin
            errors++; $display("FAIL resetrun_stale: got irq=%b done pulses %0d expected irq=1 and 0", tmr_irq, dq.size());
        end
        wq.delete();
        req = 4'b0010;
        wait_grant(5);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL resetrun_grant: got %b expected 0010", grant); end
        req = '0;
        wait_idle(40);
        checks++; if (dq.size() !== 1 || dq[0] !== 4'b0010 || wq.size() !== 4 || wq[3].a !== 3'd0) begin
            errors++; $display("FAIL resetrun_done: got %0d pulses %0d writes expected one 0010 and 4", dq.size(), wq.size());
        end
        checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL resetrun_irqclr: got %b expected 0", tmr_irq); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_periods();
        test_cancel();
        test_irq_cancel();
        test_random();
        test_reset_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
